// File: rtl/bti_blk_rd_pkg.sv
// Shared definitions for the BTI block reader: transaction-id width,
// controller state encoding and a small id-sequencing helper.
package bti_blk_rd_pkg;

    // Width of the BTI transaction id carried on both request and response packets.
    localparam int BTI_TIDW = 4;

    // Job controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Next transaction id in sequence; wraps modulo 2^BTI_TIDW.
    function automatic logic [BTI_TIDW-1:0] tid_inc(input logic [BTI_TIDW-1:0] tid);
        return tid + {{(BTI_TIDW-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/bti_blk_rd_if.sv
// BTI request and response channels. Packet fields are flattened into
// pkt_* members so the widths can follow the interface parameters.

interface bti_req_if_t
    import bti_blk_rd_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic                vld;
    logic                rdy;
    logic [AW-1:0]       pkt_addr;
    logic [BTI_TIDW-1:0] pkt_tid;
    logic                pkt_we;
    logic [DW-1:0]       pkt_wdata;

    modport mst (output vld, pkt_addr, pkt_tid, pkt_we, pkt_wdata, input rdy);
    modport slv (input vld, pkt_addr, pkt_tid, pkt_we, pkt_wdata, output rdy);
endinterface

interface bti_rsp_if_t
    import bti_blk_rd_pkg::*;
#(
    parameter int DW = 32
);
    logic                vld;
    logic                rdy;
    logic [BTI_TIDW-1:0] pkt_tid;
    logic [DW-1:0]       pkt_data;
    logic                pkt_ok;

    modport mst (output vld, pkt_tid, pkt_data, pkt_ok, input rdy);
    modport slv (input vld, pkt_tid, pkt_data, pkt_ok, output rdy);
endinterface

// File: rtl/bti_blk_rd_sync_fifo.sv
// Single-clock FIFO holding read data between the BTI response channel and
// the output stream. A push into a full FIFO is accepted when a pop happens
// in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    localparam logic [PW-1:0] C_PTR_ONE = PW'(1);
    localparam logic [CW-1:0] C_CNT_ONE = CW'(1);
    localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_cnt;
    logic             w_full;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_empty = (r_cnt == {CW{1'b0}});
    assign w_full  = (r_cnt == C_DEPTH);
    assign o_data  = r_mem[r_rd_ptr];

    // Qualify push/pop: a read frees a slot that the same-cycle write may use.
    always_comb begin
        w_rd_en = i_pop & ~o_empty;
        w_wr_en = i_push & (~w_full | w_rd_en);
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_cnt    <= {CW{1'b0}};
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_cnt <= r_cnt + C_CNT_ONE;
                2'b01:   r_cnt <= r_cnt - C_CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage array; cleared on reset so no stale data is ever visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/bti_blk_rd.sv
// BTI block reader: on start, issues len sequential word reads from
// base_addr over the BTI request channel, collects the in-order responses
// into a FIFO and streams the data out. Issue is credit-limited so that
// outstanding reads plus buffered words never exceed MAX_OUT, which is
// what lets the response channel stay permanently ready while busy.
module bti_blk_rd
    import bti_blk_rd_pkg::*;
#(
    parameter int BTI_AW  = 32,
    parameter int BTI_DW  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BTI_AW-1:0] base_addr,
    input  logic [15:0]       len,
    bti_req_if_t.mst          bti_req_mst,
    bti_rsp_if_t.slv          bti_rsp_slv,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [BTI_DW-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    // Credit counter covers outstanding reads plus FIFO occupancy (0..MAX_OUT).
    localparam int CW = $clog2(MAX_OUT) + 1;
    localparam logic [CW-1:0]     C_MAX      = CW'(MAX_OUT);
    localparam logic [CW-1:0]     C_ONE      = CW'(1);
    localparam logic [BTI_AW-1:0] C_WORD_INC = BTI_AW'(4);

    state_e              r_state;
    state_e              w_state_nxt;

    logic [BTI_AW-1:0]   r_addr;
    logic [BTI_AW-1:0]   w_addr_nxt;
    logic [BTI_TIDW-1:0] r_tid;
    logic [BTI_TIDW-1:0] w_tid_nxt;
    logic [15:0]         r_left;
    logic [15:0]         w_left_nxt;
    logic                r_req_vld;
    logic                w_req_vld_nxt;
    logic [CW-1:0]       r_used;
    logic [CW-1:0]       w_used_nxt;
    logic [BTI_TIDW-1:0] r_exp_tid;
    logic [BTI_TIDW-1:0] w_exp_tid_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_err;
    logic                w_err_nxt;

    logic                w_issue;
    logic                w_rsp_fire;
    logic                w_rsp_bad;
    logic                w_pop;
    logic                w_start_ok;
    logic                w_fifo_empty;

    assign w_issue    = r_req_vld & bti_req_mst.rdy;
    assign w_rsp_fire = bti_rsp_slv.vld & r_busy;
    assign w_rsp_bad  = (bti_rsp_slv.pkt_tid != r_exp_tid) | ~bti_rsp_slv.pkt_ok;
    assign w_pop      = ~w_fifo_empty & out_rdy;
    assign w_start_ok = start & (r_state == ST_IDLE);

    // Credit usage: a response moves a credit from outstanding into the FIFO,
    // so only issue and pop change the total.
    always_comb begin
        w_used_nxt = r_used;
        if (w_issue & ~w_pop) begin
            w_used_nxt = r_used + C_ONE;
        end else if (~w_issue & w_pop) begin
            w_used_nxt = r_used - C_ONE;
        end else begin
            w_used_nxt = r_used;
        end
    end

    // Next-state decode plus the status outputs that follow the next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = (len == 16'd0) ? ST_DONE : ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_issue && (r_left == 16'd1)) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (r_used == {CW{1'b0}}) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    // Request generator. vld is registered from credit state that only moves
    // on issue/pop, so a presented request stays presented until accepted.
    always_comb begin
        w_addr_nxt    = r_addr;
        w_tid_nxt     = r_tid;
        w_left_nxt    = r_left;
        w_req_vld_nxt = 1'b0;
        if (w_start_ok) begin
            w_addr_nxt    = base_addr;
            w_tid_nxt     = {BTI_TIDW{1'b0}};
            w_left_nxt    = len;
            w_req_vld_nxt = (len != 16'd0);
        end else if (r_state == ST_RUN) begin
            if (w_issue) begin
                w_addr_nxt = r_addr + C_WORD_INC;
                w_tid_nxt  = tid_inc(r_tid);
                w_left_nxt = r_left - 16'd1;
            end else begin
                w_addr_nxt = r_addr;
                w_tid_nxt  = r_tid;
                w_left_nxt = r_left;
            end
            w_req_vld_nxt = (w_left_nxt != 16'd0) && (w_used_nxt < C_MAX);
        end else begin
            w_req_vld_nxt = 1'b0;
        end
    end

    // Response checker: in-order tid tracking and sticky per-job error.
    always_comb begin
        w_exp_tid_nxt = r_exp_tid;
        w_err_nxt     = r_err;
        if (w_start_ok) begin
            w_exp_tid_nxt = {BTI_TIDW{1'b0}};
            w_err_nxt     = 1'b0;
        end else if (w_rsp_fire) begin
            w_exp_tid_nxt = tid_inc(r_exp_tid);
            w_err_nxt     = r_err | w_rsp_bad;
        end else begin
            w_exp_tid_nxt = r_exp_tid;
            w_err_nxt     = r_err;
        end
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= {BTI_AW{1'b0}};
            r_tid     <= {BTI_TIDW{1'b0}};
            r_left    <= 16'd0;
            r_req_vld <= 1'b0;
            r_used    <= {CW{1'b0}};
            r_exp_tid <= {BTI_TIDW{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_addr    <= w_addr_nxt;
            r_tid     <= w_tid_nxt;
            r_left    <= w_left_nxt;
            r_req_vld <= w_req_vld_nxt;
            r_used    <= w_used_nxt;
            r_exp_tid <= w_exp_tid_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    sync_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (BTI_DW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rsp_fire),
        .i_data  (bti_rsp_slv.pkt_data),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_empty (w_fifo_empty)
    );

    assign bti_req_mst.vld       = r_req_vld;
    assign bti_req_mst.pkt_addr  = r_addr;
    assign bti_req_mst.pkt_tid   = r_tid;
    assign bti_req_mst.pkt_we    = 1'b0;
    assign bti_req_mst.pkt_wdata = {BTI_DW{1'b0}};
    assign bti_rsp_slv.rdy       = r_busy;

    assign out_vld = ~w_fifo_empty;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_bti_blk_rd.sv
// Scoreboard bench for bti_blk_rd: a ROM-like BTI slave, request/response
// monitors, an output-data scoreboard and a sticky-error model.
module tb_bti_blk_rd;
    import bti_blk_rd_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'h0;
    logic [15:0] len = 16'h0;
    logic        out_vld;
    logic        out_rdy = 1'b1;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic        err;

    bti_req_if_t #(.AW(AW), .DW(DW)) u_req ();
    bti_rsp_if_t #(.DW(DW))          u_rsp ();

    bti_blk_rd #(.BTI_AW(AW), .BTI_DW(DW), .MAX_OUT(MAXO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .len         (len),
        .bti_req_mst (u_req.mst),
        .bti_rsp_slv (u_rsp.slv),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [3:0] tid; logic [31:0] addr; } req_t;
    typedef struct packed { logic [3:0] tid; logic [31:0] data; logic ok; } rsp_t;

    req_t        exp_req_q[$];
    logic [31:0] exp_dat_q[$];
    rsp_t        slv_q[$];

    int   n_chk = 0;
    int   n_fail = 0;
    int   req_cnt = 0;
    int   vld_cycles = 0;
    int   done_cnt = 0;
    bit   rand_rdy = 1'b0;
    int   bad_tid = -1;
    logic err_m = 1'b0;
    logic err_m_nxt = 1'b0;
    bit   stall_prev = 1'b0;
    req_t held;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name, input string msg);
        n_chk++;
        n_fail++;
        $display("FAIL %s: %s at %0t", name, msg, $time);
    endtask

    // Slave driver: random or constant request rdy, zero-wait in-order responses.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            u_req.rdy      = 1'b0;
            u_rsp.vld      = 1'b0;
            u_rsp.pkt_tid  = 4'h0;
            u_rsp.pkt_data = 32'h0;
            u_rsp.pkt_ok   = 1'b0;
        end else begin
            u_req.rdy = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (slv_q.size() != 0) begin
                u_rsp.vld = 1'b1;
                {u_rsp.pkt_tid, u_rsp.pkt_data, u_rsp.pkt_ok} = slv_q[0];
            end else begin
                u_rsp.vld      = 1'b0;
                u_rsp.pkt_tid  = 4'h0;
                u_rsp.pkt_data = 32'h0;
                u_rsp.pkt_ok   = 1'b0;
            end
        end
    end

    // Request monitor: order/address/tid check, stability while stalled, slave queueing.
    always @(negedge clk) begin
        req_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (u_rsp.vld && u_rsp.rdy && slv_q.size() != 0) void'(slv_q.pop_front());
            if (u_req.vld) begin
                vld_cycles++;
                if (stall_prev) chk("req_pkt_stable", {u_req.pkt_tid, u_req.pkt_addr}, held);
                if (u_req.rdy) begin
                    req_cnt++;
                    stall_prev = 1'b0;
                    if (exp_req_q.size() == 0) begin
                        fail("req_unexpected", $sformatf("addr 0x%0h tid %0d", u_req.pkt_addr, u_req.pkt_tid));
                    end else begin
                        e = exp_req_q.pop_front();
                        chk("req_addr", u_req.pkt_addr, e.addr);
                        chk("req_tid", u_req.pkt_tid, e.tid);
                    end
                    chk("req_we", u_req.pkt_we, 0);
                    slv_q.push_back({u_req.pkt_tid, rom(u_req.pkt_addr),
                                     !((bad_tid >= 0) && (int'(u_req.pkt_tid) == bad_tid))});
                end else begin
                    stall_prev = 1'b1;
                    held = {u_req.pkt_tid, u_req.pkt_addr};
                end
            end else if (stall_prev) begin
                chk("req_vld_held", u_req.vld, 1);
                stall_prev = 1'b0;
            end
        end
    end

    // Output scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_vld && out_rdy) begin
            if (exp_dat_q.size() == 0) fail("out_unexpected", $sformatf("data 0x%0h", out_data));
            else chk("out_data", out_data, exp_dat_q.pop_front());
        end
    end

    // Sticky error model and done pulse counter.
    always @(negedge clk) begin
        if (!rst_n) begin
            err_m     = 1'b0;
            err_m_nxt = 1'b0;
        end else begin
            err_m = err_m_nxt;
            chk("err_track", err, err_m);
            if (done) done_cnt++;
            if (start && !busy) err_m_nxt = 1'b0;
            else if (u_rsp.vld && u_rsp.rdy && !u_rsp.pkt_ok) err_m_nxt = 1'b1;
        end
    end

    task automatic expect_job(input logic [31:0] b, input int l);
        for (int i = 0; i < l; i++) begin
            logic [31:0] a;
            a = b + 32'(i) * 32'd4;
            exp_req_q.push_back({4'(i), a});
            exp_dat_q.push_back(rom(a));
        end
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] l);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!busy) return;
        end
        fail(name, "timeout waiting for busy to drop");
    endtask

    task automatic finish_job(input int d0, input int r0, input int l, input logic exp_err);
        wait_idle(2000, "job_timeout");
        chk("done_pulses", done_cnt - d0, 1);
        chk("req_count", req_cnt - r0, l);
        chk("words_left", exp_dat_q.size(), 0);
        chk("reqs_left", exp_req_q.size(), 0);
        chk("err_end", err, exp_err);
    endtask

    task automatic run_job(input logic [31:0] b, input int l, input logic exp_err);
        int d0;
        int r0;
        d0 = done_cnt;
        r0 = req_cnt;
        expect_job(b, l);
        pulse_start(b, 16'(l));
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        finish_job(d0, r0, l, exp_err);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_req_vld", u_req.vld, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_rsp_rdy", u_rsp.rdy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int r0;
        int v0;
        bit hit;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs();

        // Basic sequential read.
        run_job(32'h0000_1000, 8, 1'b0);

        // Zero-length job: done pulse soon, no request traffic.
        v0 = vld_cycles;
        d0 = done_cnt;
        pulse_start(32'h0000_1000, 16'd0);
        hit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) hit = 1'b1;
        end
        chk("len0_done_seen", hit, 1);
        chk("len0_done_once", done_cnt - d0, 1);
        chk("len0_no_req", vld_cycles - v0, 0);
        chk("len0_idle", busy, 0);

        // Output back-pressure: only MAX_OUT reads may be in flight or buffered.
        out_rdy = 1'b0;
        d0 = done_cnt;
        r0 = req_cnt;
        expect_job(32'h0000_2000, 10);
        pulse_start(32'h0000_2000, 16'd10);
        repeat (50) @(negedge clk);
        chk("stall_issued", req_cnt - r0, MAXO);
        chk("stall_busy", busy, 1);
        out_rdy = 1'b1;
        finish_job(d0, r0, 10, 1'b0);

        // Response word 3 flagged not-ok: err sticky through done, data still delivered.
        bad_tid = 3;
        run_job(32'h0000_5000, 5, 1'b1);
        bad_tid = -1;
        repeat (5) @(negedge clk);
        chk("err_hold_after_done", err, 1);
        run_job(32'h0000_6000, 3, 1'b0);

        // Random request back-pressure, address wrap, start pulsed while busy.
        rand_rdy = 1'b1;
        d0 = done_cnt;
        r0 = req_cnt;
        expect_job(32'hFFFF_FFF0, 6);
        pulse_start(32'hFFFF_FFF0, 16'd6);
        repeat (2) @(posedge clk);
        #1;
        chk("busy_before_ignored_start", busy, 1);
        start = 1'b1; base_addr = 32'h0000_9000; len = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        finish_job(d0, r0, 6, 1'b0);
        rand_rdy = 1'b0;

        // Reset in the middle of a job after three issues, then a fresh job.
        r0 = req_cnt;
        expect_job(32'h0000_3000, 8);
        pulse_start(32'h0000_3000, 16'd8);
        hit = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (req_cnt - r0 >= 3) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reset_three_issued", hit, 1);
        rst_n = 1'b0;
        exp_req_q.delete();
        exp_dat_q.delete();
        slv_q.delete();
        @(negedge clk);
        chk_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_job(32'h0000_4000, 2, 1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bti_blk_rd.md
BTI_BLK_RD -- requirements
Module: bti_blk_rd

Interface
REQ-001 SHALL have parameter BTI_AW, default 32, BTI address width.
REQ-002 SHALL have parameter BTI_DW, default 32, BTI data width.
REQ-003 SHALL have parameter MAX_OUT, default 4, power of two 2..16, credit limit and FIFO depth.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, single-cycle job request, honoured only in IDLE.
REQ-007 SHALL have port base_addr, input, BTI_AW, word-aligned start byte address, sampled with start.
REQ-008 SHALL have port len, input, 16, word count, sampled with start.
REQ-009 SHALL have port bti_req_mst, bti_req_if_t.mst, -, BTI request channel (vld/rdy/pkt).
REQ-010 SHALL have port bti_rsp_slv, bti_rsp_if_t.slv, -, BTI response channel (vld/rdy/pkt with tid, data, ok).
REQ-011 SHALL have ports out_vld (output, 1), out_rdy (input, 1), out_data (output, BTI_DW), read-data stream.
REQ-012 SHALL have ports busy (output, 1), done (output, 1, single-cycle pulse), err (output, 1, sticky per job).

Function
REQ-013 SHALL implement FSM IDLE -> RUN (start, len!=0) -> DRAIN (last request accepted) -> DONE (outstanding==0 and FIFO empty) -> IDLE.
REQ-014 SHALL go IDLE -> DONE directly on start with len==0; no BTI traffic.
REQ-015 SHALL assert busy in RUN, DRAIN and DONE; done exactly one cycle, in DONE.
REQ-016 SHALL issue read i at base_addr + 4*i, i = 0..len-1, in order; pkt.tid = i mod 2^BTI_TIDW; other request fields zero (read).
REQ-017 SHALL hold vld and pkt stable from assertion until vld&rdy; request counts as issued only on vld&rdy.
REQ-018 SHALL assert bti_req_mst.vld only when outstanding + FIFO occupancy < MAX_OUT; one issue per cycle max.
REQ-019 SHALL keep bti_rsp_slv.rdy = 1 while busy; credit rule guarantees FIFO space.
REQ-020 SHALL push rsp data into FIFO on rsp vld&rdy; outstanding incremented on issue, decremented on response; same-cycle both leaves it unchanged.
REQ-021 SHALL check responses arrive in order: rsp tid != expected tid, or ok==0, sets err; data still forwarded, job continues.
REQ-022 SHALL present FIFO head on out_data with out_vld = !empty; pop on out_vld&out_rdy; same-cycle push and pop on full FIFO allowed.
REQ-023 SHALL allow out_rdy=0 indefinitely; issue stalls via credit rule, no data lost.
REQ-024 SHALL clear err on accepted start; err held after done until next start.
REQ-025 SHALL ignore start while busy.
REQ-026 SHALL wrap address modulo 2^BTI_AW with no error.

Reset
REQ-027 SHALL on rst_n low: FSM IDLE, counters zero, FIFO empty, busy=0, done=0, err=0, req vld=0, out_vld=0, rsp rdy=0.
REQ-028 SHALL abandon an in-flight job on reset mid-operation; late responses after reset are system-level illegal and not handled.

Structure
REQ-029 SHALL place FSM state enum in shared package bti_blk_rd_pkg; BTI packet types and BTI_TIDW come from existing bti.svh.
REQ-030 SHALL instantiate one sub-module sync_fifo (depth MAX_OUT, width BTI_DW) for read data.
REQ-031 SHALL have no combinational path from bti_rsp_slv.vld to bti_req_mst.vld.

Verification
REQ-032 SHALL verify: base 0x1000, len 8, zero-wait ROM slave, out_rdy=1 -> addrs 0x1000..0x101C, tids 0..7, data in order, done once, err=0.
REQ-033 SHALL verify: len 0 -> done next-but-one cycle, no req vld ever.
REQ-034 SHALL verify: len 10, out_rdy=0 for 50 cycles -> exactly MAX_OUT=4 requests issued, then stall; release -> remaining 6 issued, all 10 words delivered.
REQ-035 SHALL verify: slave rsp word 3 ok=0 -> err=1 from that response through done, all 5 of len 5 delivered; next start clears err.
REQ-036 SHALL verify: random rdy on req channel, pkt stable while stalled, and start pulsed while busy ignored.
REQ-037 SHALL verify: rst_n low during RUN after 3 issues -> all outputs reset values next edge; new job len 2 completes correctly.
